// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory bus of the data-memory arbiter.
// The slave side is the arbiter; the master side is the environment (requesters plus memory array).
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 5
);
   logic [2:0]          req;
   logic [2:0]          we;
   logic [2:0]          swap;
   logic [3*ADDR_W-1:0] addr;
   logic [95:0]         wdata;
   logic [2:0]          ack;
   logic [31:0]         rdata;
   logic                busy;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_we;
   logic [7:0]          mem_wdata;
   logic [7:0]          mem_rdata;

   modport master (
      output req, we, swap, addr, wdata, mem_rdata,
      input  ack, rdata, busy, mem_addr, mem_we, mem_wdata
   );

   modport slave (
      input  req, we, swap, addr, wdata, mem_rdata,
      output ack, rdata, busy, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a byte-wide data memory between three word requesters.
// Each word access is serialised big-endian over four byte cycles; swap is an atomic read-then-write.
module dmem_arbiter #(
   parameter int unsigned ADDR_W = 5
) (
   input logic           clk,
   input logic           reset,
   dmem_arbiter_if.slave bus
);
   localparam int unsigned WORD_W = 32;
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t              state;
   logic [1:0]          cnt;
   logic [1:0]          cnt_nx;
   logic [1:0]          gnt;
   logic [1:0]          last_grant;
   logic [1:0]          pick;
   logic [ADDR_W-1:0]   base;
   logic [ADDR_W-1:0]   addr_sel;
   logic [WORD_W-1:0]   wbuf;
   logic [WORD_W-1:0]   shift;
   logic [WORD_W-1:0]   wdata_sel;
   logic                op_swap;
   logic                op_write;
   logic                wr_sel;

   function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0] w, input logic [1:0] i);
      case (i)
         2'd0:    byte_sel = w[31:24];
         2'd1:    byte_sel = w[23:16];
         2'd2:    byte_sel = w[15:8];
         default: byte_sel = w[7:0];
      endcase
   endfunction

   function automatic logic [WORD_W-1:0] byte_put(input logic [WORD_W-1:0] w, input logic [1:0] i,
                                                  input logic [BYTE_W-1:0] b);
      byte_put = w;
      case (i)
         2'd0:    byte_put[31:24] = b;
         2'd1:    byte_put[23:16] = b;
         2'd2:    byte_put[15:8]  = b;
         default: byte_put[7:0]   = b;
      endcase
   endfunction

   assign cnt_nx = cnt + 2'd1;

   // Round-robin winner: search starts just after the last granted requester
   always_comb begin
      pick = 2'd0;
      case (last_grant)
         2'd0: begin
            if (bus.req[1])      pick = 2'd1;
            else if (bus.req[2]) pick = 2'd2;
            else                 pick = 2'd0;
         end
         2'd1: begin
            if (bus.req[2])      pick = 2'd2;
            else if (bus.req[0]) pick = 2'd0;
            else                 pick = 2'd1;
         end
         default: begin
            if (bus.req[0])      pick = 2'd0;
            else if (bus.req[1]) pick = 2'd1;
            else                 pick = 2'd2;
         end
      endcase
   end

   // Request fields of the candidate winner
   always_comb begin
      addr_sel  = bus.addr[0 +: ADDR_W];
      wdata_sel = bus.wdata[0 +: WORD_W];
      case (pick)
         2'd1: begin
            addr_sel  = bus.addr[ADDR_W +: ADDR_W];
            wdata_sel = bus.wdata[WORD_W +: WORD_W];
         end
         2'd2: begin
            addr_sel  = bus.addr[2*ADDR_W +: ADDR_W];
            wdata_sel = bus.wdata[2*WORD_W +: WORD_W];
         end
         default: ;
      endcase
      wr_sel = bus.we[pick] & ~bus.swap[pick];
   end

   // Transaction sequencer; memory strobes are launched one edge ahead of their byte cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= 2'd0;
         gnt           <= 2'd0;
         last_grant    <= 2'd2;
         base          <= '0;
         wbuf          <= '0;
         shift         <= '0;
         op_swap       <= 1'b0;
         op_write      <= 1'b0;
         bus.ack       <= 3'b000;
         bus.rdata     <= '0;
         bus.busy      <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_wdata <= '0;
      end else begin
         bus.ack <= 3'b000;
         case (state)
            IDLE: begin
               if (|bus.req) begin
                  gnt          <= pick;
                  last_grant   <= pick;
                  base         <= addr_sel;
                  wbuf         <= wdata_sel;
                  op_swap      <= bus.swap[pick];
                  op_write     <= wr_sel;
                  cnt          <= 2'd0;
                  bus.busy     <= 1'b1;
                  bus.mem_addr <= addr_sel;
                  if (wr_sel) begin
                     state         <= WR;
                     bus.mem_we    <= 1'b1;
                     bus.mem_wdata <= byte_sel(wdata_sel, 2'd0);
                  end else begin
                     state      <= RD;
                     bus.mem_we <= 1'b0;
                  end
               end
            end
            RD: begin
               shift        <= byte_put(shift, cnt, bus.mem_rdata);
               cnt          <= cnt_nx;
               bus.mem_addr <= base + ADDR_W'(cnt_nx);
               if (cnt == 2'd3) begin
                  if (op_swap) begin
                     state         <= WR;
                     bus.mem_we    <= 1'b1;
                     bus.mem_wdata <= byte_sel(wbuf, 2'd0);
                  end else begin
                     state     <= DONE;
                     bus.ack   <= 3'b001 << gnt;
                     bus.rdata <= byte_put(shift, cnt, bus.mem_rdata);
                  end
               end
            end
            WR: begin
               cnt           <= cnt_nx;
               bus.mem_addr  <= base + ADDR_W'(cnt_nx);
               bus.mem_wdata <= byte_sel(wbuf, cnt_nx);
               if (cnt == 2'd3) begin
                  state      <= DONE;
                  bus.mem_we <= 1'b0;
                  bus.ack    <= 3'b001 << gnt;
                  bus.rdata  <= op_write ? '0 : shift;
               end
            end
            DONE: begin
               state      <= IDLE;
               bus.busy   <= 1'b0;
               bus.mem_we <= 1'b0;
               bus.rdata  <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the byte-wide 32-entry data memory between three word-access requesters: 0 = core load/store port, 1 = stack unit (push/pop/swap for call/return), 2 = external loader/debug port.
- Serialises each 32-bit access into big-endian byte cycles (byte at addr holds bits 31:24) and returns a one-cycle acknowledge with read data.
- Sits between the requesters and the data memory array; it is the only agent driving the memory address, write-enable and write-data lines.

Parameters:
ADDR_W, 5, byte-address width; memory depth is 2**ADDR_W; all address arithmetic wraps modulo 2**ADDR_W.

Ports:
clk  input  1  clock; all state changes on rising edge.
reset  input  1  asynchronous, active-high reset.
req  input  3  request per requester, bit i = requester i.
we  input  3  bit i: 1 = write word, 0 = read word (ignored when swap[i]=1).
swap  input  3  bit i: atomic read-then-write of the same word; old value returned.
addr  input  3*ADDR_W  requester i base byte address at bits [i*ADDR_W +: ADDR_W].
wdata  input  96  requester i write word at bits [i*32 +: 32].
ack  output  3  one-cycle completion pulse, bit i.
rdata  output  32  read or old (swap) word; valid only while ack is nonzero.
busy  output  1  high in every state except IDLE.
mem_addr  output  ADDR_W  byte address to memory.
mem_we  output  1  byte write strobe; memory writes on the rising edge.
mem_wdata  output  8  byte to write.
mem_rdata  input  8  combinational byte read at mem_addr.

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE, ack=0, rdata=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0, byte counter=0, last_grant=2, so requester 0 has top priority first.
- States: IDLE, RD, WR, DONE. Byte counter cnt is 2 bits.
- IDLE:
  - If any req bit is set, grant round-robin: search order starts at (last_grant+1) mod 3.
  - Latch grant index g, addr, wdata, and op: read, write, or swap. Swap dominates we.
  - Set last_grant=g and cnt=0.
  - Next state is RD for read/swap, WR for write. With no request, stay in IDLE.
- RD:
  - mem_addr = base+cnt (wrapping), mem_we=0.
  - On each edge, capture mem_rdata into shift register byte (3-cnt); cnt==0 fills bits 31:24.
  - After cnt==3: next state is WR if swap, else DONE. cnt resets to 0.
- WR:
  - mem_addr = base+cnt, mem_we=1, mem_wdata = latched wdata bits [31-8*cnt -: 8].
  - After cnt==3: next state DONE.
- DONE:
  - ack[g]=1 for exactly this cycle. rdata = captured word for read/swap, 0 for a plain write.
  - mem_we=0. Next state IDLE.
- Latency, counted in cycles after the IDLE grant edge:
  - read: 4 byte cycles, then ack (ack in 5th cycle).
  - write: 4 byte cycles, then ack (ack in 5th cycle).
  - swap: 8 byte cycles, then ack (ack in 9th cycle).
- Requester hold rules:
  - A requester must hold req until it sees ack, and drop req on the next edge.
  - addr, wdata, we and swap are sampled only at grant; later changes are ignored.
- Swap is atomic: no other grant occurs between its read and write phases.
- Address wrap: base 30 touches 30, 31, 0, 1.
- Simultaneous requests: exactly one grant per IDLE cycle; the others wait, and request order is not otherwise tracked.
- A req that rises during a busy transaction is considered at the next IDLE.
- Reset mid-transaction: abort immediately, mem_we drops asynchronously, no ack is issued. Bytes already written stay written (no rollback).
- mem_addr, mem_we and mem_wdata are registered or decoded from state only; they have no combinational path from req.

Test Plan:
- Read: memory bytes 4..7 = 12 34 56 78; req[0] with addr 4, we=0 -> mem_addr 4,5,6,7 in 4 consecutive cycles, then ack=3'b001 with rdata=32'h12345678; busy high for 5 cycles.
- Write wrap: req[2] with addr 30, wdata=32'hDEADBEEF -> writes 30=DE, 31=AD, 0=BE, 1=EF; ack[2] pulses with rdata=0.
- Swap: memory bytes 28..31 = 00 00 00 40; req[1] with swap, wdata=32'h0000001C -> 8 byte cycles, ack[1] with rdata=32'h00000040, memory bytes 28..31 then read 00 00 00 1C.
- Round-robin: all three req held continuously from reset -> grant order 0,1,2,0; each ack separated by exactly the transaction length plus one IDLE cycle.
- Atomicity: req[0] raised during the RD phase of a swap by requester 1 -> no grant until after ack[1]; requester 0 is served next.
- Reset mid-write: assert reset during the 3rd WR cycle -> mem_we=0 immediately, no ack, busy=0. After release, req[0] is granted first, and only the first two bytes of the aborted write are changed in memory.
